// File: rtl/fmdll_pkg.sv
// Shared FMDLL definitions: frame-FSM state encoding and the minimum legal frame length.
package fmdll_pkg;

  localparam int unsigned N_MIN = 2;

  typedef logic [1:0] fmdll_state_t;

  localparam fmdll_state_t ST_RUN   = 2'd0;
  localparam fmdll_state_t ST_PEND  = 2'd1;
  localparam fmdll_state_t ST_BLANK = 2'd2;

endpackage

// File: rtl/fmdll_frame_cnt.sv
// Frame counter: counts 0..n_act-1, reloads frame length at a wrap, and emits the
// registered once-per-frame DIV_M pulse with optional suppression.
module fmdll_frame_cnt #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned N_DEFAULT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] n_load_i,
  input  logic             suppress_i,
  output logic             wrap_o,
  output logic             div_m_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_act_q, n_act_d;
  logic             div_m_q, div_m_d;

  assign wrap_o  = run_i && (cnt_q == n_act_q - CNT_W'(1));
  assign div_m_o = div_m_q;

  // DIV_M is decoded from next-state values so it is high in the same cycle
  // that div_cnt sits at n_act-1, while still coming straight from a flop.
  always_comb begin
    n_act_d = load_i ? n_load_i : n_act_q;
    cnt_d   = cnt_q;
    if (run_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
    div_m_d = (cnt_d == n_act_d - CNT_W'(1)) && !suppress_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      n_act_q <= CNT_W'(N_DEFAULT);
      div_m_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      n_act_q <= n_act_d;
      div_m_q <= div_m_d;
    end
  end

endmodule

// File: rtl/fmdll_div_m_gen.sv
// FMDLL frame generator: clk/2 and clk/4 divider, N/M reconfiguration handshake,
// frame-boundary application of new settings and DIV_M blanking after a mode change.
module fmdll_div_m_gen
  import fmdll_pkg::*;
#(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned N_DEFAULT    = 4,
  parameter int unsigned BLANK_FRAMES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_n,
  input  logic             cfg_m,
  output logic             clk2,
  output logic             clk4,
  output logic             M,
  output logic             DIV_M,
  output logic             blank
);

  localparam int unsigned BLANK_W = (BLANK_FRAMES < 2) ? 1 : $clog2(BLANK_FRAMES + 1);

  logic [1:0]         q_q;
  logic               started_q;
  logic               ready_q, ready_d;
  fmdll_state_t       state_q, state_d;
  logic [CNT_W-1:0]   shadow_n_q, shadow_n_d;
  logic               shadow_m_q, shadow_m_d;
  logic               m_q, m_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic               blank_q, blank_d;
  logic               wrap;
  logic               load;
  logic               suppress;

  assign clk2      = q_q[0];
  assign clk4      = q_q[1];
  assign cfg_ready = ready_q;
  assign M         = m_q;
  assign blank     = blank_q;

  always_comb begin
    state_d     = state_q;
    shadow_n_d  = shadow_n_q;
    shadow_m_d  = shadow_m_q;
    m_d         = m_q;
    blank_cnt_d = blank_cnt_q;
    load        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_valid && ready_q) begin
          shadow_n_d = (cfg_n < CNT_W'(N_MIN)) ? CNT_W'(N_MIN) : cfg_n;
          shadow_m_d = cfg_m;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          load = 1'b1;
          m_d  = shadow_m_q;
          if (shadow_m_q != m_q) begin
            state_d     = ST_BLANK;
            blank_cnt_d = BLANK_W'(BLANK_FRAMES);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_BLANK: begin
        if (wrap) begin
          if (blank_cnt_q == BLANK_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            blank_cnt_d = blank_cnt_q - BLANK_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    ready_d  = (state_d == ST_RUN);
    blank_d  = (state_d == ST_BLANK);
    suppress = blank_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      started_q   <= 1'b0;
      ready_q     <= 1'b0;
      state_q     <= ST_RUN;
      shadow_n_q  <= '0;
      shadow_m_q  <= 1'b0;
      m_q         <= 1'b0;
      blank_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      q_q         <= q_q + 2'd1;
      started_q   <= 1'b1;
      ready_q     <= ready_d;
      state_q     <= state_d;
      shadow_n_q  <= shadow_n_d;
      shadow_m_q  <= shadow_m_d;
      m_q         <= m_d;
      blank_cnt_q <= blank_cnt_d;
      blank_q     <= blank_d;
    end
  end

  fmdll_frame_cnt #(
    .CNT_W     (CNT_W),
    .N_DEFAULT (N_DEFAULT)
  ) u_frame_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .run_i      (started_q),
    .load_i     (load),
    .n_load_i   (shadow_n_q),
    .suppress_i (suppress),
    .wrap_o     (wrap),
    .div_m_o    (DIV_M)
  );

endmodule

// File: tb/tb_fmdll_div_m_gen.sv
// Directed bench for fmdll_div_m_gen: per-cycle expected DIV_M/ready/blank/M masks.
module tb_fmdll_div_m_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_n = '0;
  logic       cfg_m = 1'b0;
  logic       clk2, clk4, M, DIV_M, blank;

  int checks = 0;
  int failures = 0;
  int cyc = -1;

  logic [63:0] dm, rlo, bl, mm;

  fmdll_div_m_gen #(
    .CNT_W        (4),
    .N_DEFAULT    (4),
    .BLANK_FRAMES (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_n     (cfg_n),
    .cfg_m     (cfg_m),
    .clk2      (clk2),
    .clk4      (clk4),
    .M         (M),
    .DIV_M     (DIV_M),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] r;
    r = '0;
    for (int i = a; i <= b; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] b1(input int a);
    return rng(a, a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, releases on a falling edge.
  task automatic do_reset();
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_div_m", DIV_M, 0);
    chk("rst_m", M, 0);
    chk("rst_blank", blank, 0);
    chk("rst_clk2", clk2, 0);
    chk("rst_clk4", clk4, 0);
    chk("rst_ready", cfg_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
  endtask

  // Offer is valid over cycles [ofrom, oto]; n1/m1 on the first cycle, n2/m2 afterwards.
  task automatic run(input int last, input int ofrom, input int oto,
                     input logic [3:0] n1, input logic m1,
                     input logic [3:0] n2, input logic m2);
    while (cyc < last) begin
      step();
      cfg_valid = (cyc >= ofrom) && (cyc <= oto);
      cfg_n     = (cyc == ofrom) ? n1 : n2;
      cfg_m     = (cyc == ofrom) ? m1 : m2;
      chk("div_m", DIV_M, dm[cyc]);
      chk("cfg_ready", cfg_ready, !rlo[cyc]);
      chk("blank", blank, bl[cyc]);
      chk("m", M, mm[cyc]);
      chk("clk2", clk2, (cyc + 1) % 2);
      chk("clk4", clk4, ((cyc + 1) / 2) % 2);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Default frame N=4
    do_reset();
    dm = b1(3) | b1(7) | b1(11) | b1(15); rlo = '0; bl = '0; mm = '0;
    run(15, 100, 0, 4'd0, 1'b0, 4'd0, 1'b0);

    // N=6, M unchanged, offered at cycle 5
    do_reset();
    dm = b1(3) | b1(7) | b1(13) | b1(19); rlo = rng(6, 7); bl = '0; mm = '0;
    run(20, 5, 5, 4'd6, 1'b0, 4'd6, 1'b0);

    // Mode change to M=1 with one blanked frame
    do_reset();
    dm = b1(3) | b1(7) | b1(15) | b1(19); rlo = rng(6, 11); bl = rng(8, 11); mm = rng(8, 19);
    run(19, 5, 5, 4'd4, 1'b1, 4'd4, 1'b1);

    // Same N/M re-sent
    do_reset();
    dm = b1(3) | b1(7) | b1(11) | b1(15); rlo = rng(6, 7); bl = '0; mm = '0;
    run(15, 5, 5, 4'd4, 1'b0, 4'd4, 1'b0);

    // Clamp: cfg_n=0 and cfg_n=1 give frame length 2
    do_reset();
    dm = b1(3) | b1(5) | b1(7) | b1(9) | b1(11); rlo = rng(2, 3); bl = '0; mm = '0;
    run(11, 1, 1, 4'd0, 1'b0, 4'd0, 1'b0);
    do_reset();
    run(11, 1, 1, 4'd1, 1'b0, 4'd1, 1'b0);

    // Maximum frame length 15
    do_reset();
    dm = b1(3) | b1(18) | b1(33) | b1(48); rlo = rng(2, 3); bl = '0; mm = '0;
    run(50, 1, 1, 4'd15, 1'b0, 4'd15, 1'b0);

    // Transfer in the wrap cycle applies one frame later
    do_reset();
    dm = b1(3) | b1(7) | b1(13) | b1(19); rlo = rng(4, 7); bl = '0; mm = '0;
    run(20, 3, 3, 4'd6, 1'b0, 4'd6, 1'b0);

    // Reset while pending (during DIV_M high in cycle 7), then defaults resume
    do_reset();
    dm = b1(3) | b1(7); rlo = rng(6, 7); bl = '0; mm = '0;
    run(7, 5, 5, 4'd6, 1'b1, 4'd6, 1'b1);
    do_reset();
    dm = b1(3) | b1(7) | b1(11) | b1(15); rlo = '0; bl = '0; mm = '0;
    run(15, 100, 0, 4'd0, 1'b0, 4'd0, 1'b0);

    // Reset while blanking, then offer held valid through the not-ready window
    do_reset();
    dm = b1(3) | b1(7); rlo = rng(6, 9); bl = rng(8, 9); mm = rng(8, 9);
    run(9, 5, 5, 4'd4, 1'b1, 4'd4, 1'b1);
    do_reset();
    dm = b1(3) | b1(15) | b1(21); rlo = rng(2, 9); bl = rng(4, 9); mm = rng(4, 22);
    run(22, 1, 3, 4'd6, 1'b1, 4'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
